// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared pipeline definitions (opcodes, instruction field layout)
package instruction_fetch_pkg;
    localparam int INSTR_W = 16;
    localparam int OP_W    = 6;
    localparam int DATA_W  = 10;
    localparam int OP_LSB  = 10;
    localparam int ADDR_W  = 10;
    localparam logic [OP_W-1:0] OP_NOP  = 6'h00;
    localparam logic [OP_W-1:0] OP_BAEQ = 6'h04;
    localparam logic [OP_W-1:0] OP_HALT = 6'h3f;
    function automatic logic [OP_W-1:0] opcode(input logic [INSTR_W-1:0] instr);
        return instr[OP_LSB +: OP_W];
    endfunction
    function automatic logic [DATA_W-1:0] data_field(input logic [INSTR_W-1:0] instr);
        return instr[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/instruction_fetch_pc_register.sv
// pc_register: program counter with next-PC mux (branch > hold > increment).
// Ports: Clock, Reset (async active-low), branch/target redirect, hold, pc (current), pc_next (mux output).
module pc_register
    import instruction_fetch_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              branch,
    input  logic [ADDR_W-1:0] target,
    input  logic              hold,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next
);
    always_comb pc_next = branch ? target : hold ? pc : pc + ADDR_W'(1);
    always_ff @(posedge Clock or negedge Reset)
        if (!Reset) pc <= '0;
        else pc <= pc_next;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage -- drives the synchronous instruction memory and registers opcode/data for decode.
// Ports: Clock, Reset (async active-low), iInstr (memory data, 1-cycle latency), iBranchTaken/iBranchTarget
// (redirect), iStall (hold), oInstrAddr (combinational fetch address), oOperation_IF/oData_IF/oPC (registered).
// Macro IF_HALT_EN: adds the HALTED state entered when HALT is loaded into the output register.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] iInstr,
    input  logic        iBranchTaken,
    input  logic [9:0]  iBranchTarget,
    input  logic        iStall,
    output logic [9:0]  oInstrAddr,
    output logic [5:0]  oOperation_IF,
    output logic [9:0]  oData_IF,
    output logic [9:0]  oPC
);
`ifdef IF_HALT_EN
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
`else
    typedef enum logic {BOOT, RUN} state_t;
`endif
    state_t state, state_next;
    logic [9:0] pc, pc_next;
    logic load, flush;
    // PC only advances in RUN; BOOT and HALTED re-present the current address.
    pc_register u_pc (
        .Clock  (Clock),
        .Reset  (Reset),
        .branch (iBranchTaken),
        .target (iBranchTarget),
        .hold   (state != RUN || iStall),
        .pc     (pc),
        .pc_next(pc_next)
    );
    // The memory registers the address we present, so the fetch address is simply next-PC.
    assign oInstrAddr = Reset ? pc_next : '0;
    always_comb begin
        load = state == RUN && !iBranchTaken && !iStall;
        flush = iBranchTaken || state != RUN;
        state_next = state;
        if (iBranchTaken || state == BOOT) state_next = RUN;
`ifdef IF_HALT_EN
        else if (load && opcode(iInstr) == OP_HALT) state_next = HALTED;
`endif
    end
    always_ff @(posedge Clock or negedge Reset)
        if (!Reset) begin
            state         <= BOOT;
            oOperation_IF <= OP_NOP;
            oData_IF      <= '0;
            oPC           <= '0;
        end else begin
            state <= state_next;
            if (flush) begin
                oOperation_IF <= OP_NOP;
                oData_IF      <= '0;
                oPC           <= '0;
            end else if (load) begin
                oOperation_IF <= opcode(iInstr);
                oData_IF      <= data_field(iInstr);
                oPC           <= pc;
            end
        end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch with a behavioural fetch model
module tb_instruction_fetch;
    localparam logic [5:0] NOP = 6'h00;
    localparam logic [5:0] HALT = 6'h3f;
`ifdef IF_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    typedef struct {
        bit         bubble;
        logic [5:0] op;
        logic [9:0] data;
        logic [9:0] pc;
    } exp_t;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] iInstr = '0;
    logic        iBranchTaken = 1'b0;
    logic [9:0]  iBranchTarget = '0;
    logic        iStall = 1'b0;
    logic [9:0]  oInstrAddr;
    logic [5:0]  oOperation_IF;
    logic [9:0]  oData_IF;
    logic [9:0]  oPC;
    logic [15:0] mem [1024];
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    // Model: seq is the address whose instruction is delivered on the next unstalled RUN cycle.
    logic [9:0] seq;
    bit boot, halted;
    exp_t last;

    instruction_fetch dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iInstr       (iInstr),
        .iBranchTaken (iBranchTaken),
        .iBranchTarget(iBranchTarget),
        .iStall       (iStall),
        .oInstrAddr   (oInstrAddr),
        .oOperation_IF(oOperation_IF),
        .oData_IF     (oData_IF),
        .oPC          (oPC)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) iInstr <= mem[oInstrAddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clock) begin : monitor
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.bubble) check("bubble", {oOperation_IF, oData_IF}, {NOP, 10'd0});
            else check("instr", {oOperation_IF, oData_IF, oPC}, {e.op, e.data, e.pc});
        end
    end

    task automatic step(input bit br, input logic [9:0] tgt, input bit st);
        exp_t e;
        logic [9:0] a;
        @(negedge Clock);
        iBranchTaken = br;
        iBranchTarget = tgt;
        iStall = st;
        a = br ? tgt : (boot || halted || st) ? seq : seq + 10'd1;
        #1 check("addr", oInstrAddr, a);
        e = '{1'b1, NOP, 10'd0, 10'd0};
        if (br) begin
            seq = tgt;
            boot = 0;
            halted = 0;
        end else if (boot) boot = 0;
        else if (!halted) begin
            if (st) e = last;
            else begin
                e = '{1'b0, mem[seq][15:10], mem[seq][9:0], seq};
                halted = HALT_EN && mem[seq][15:10] == HALT;
                seq = seq + 10'd1;
            end
        end
        last = e;
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'($urandom), 1'b0);
    endtask

    task automatic model_reset();
        boot = 1;
        halted = 0;
        seq = '0;
        last = '{1'b1, NOP, 10'd0, 10'd0};
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        iBranchTaken = 1'b1;
        iBranchTarget = 10'h155;
        iStall = 1'b1;
        #1;
        check("rst_op", oOperation_IF, NOP);
        check("rst_data", oData_IF, 10'd0);
        check("rst_pc", oPC, 10'd0);
        check("rst_addr", oInstrAddr, 10'd0);
        @(posedge Clock);
        #2;
        iBranchTaken = 1'b0;
        iStall = 1'b0;
        Reset = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {6'($urandom_range(1, 62)), 10'(i)};
        mem[10] = {HALT, 10'd10};
        #1 Reset = 1'b0;
        #2;
        check("init_op", oOperation_IF, NOP);
        check("init_data", oData_IF, 10'd0);
        check("init_pc", oPC, 10'd0);
        check("init_addr", oInstrAddr, 10'd0);
        repeat (2) @(posedge Clock);
        #2 Reset = 1'b1;
        model_reset();
        run(9);
        repeat (3) step(1'b0, 10'($urandom), 1'b1);
        run(6);
        step(1'b1, 10'd30, 1'b0);
        run(4);
        step(1'b1, 10'd3, 1'b0);
        run(3);
        step(1'b1, 10'd200, 1'b0);
        run(3);
        step(1'b1, 10'd50, 1'b1);
        run(2);
        step(1'b1, 10'd40, 1'b0);
        step(1'b1, 10'd1020, 1'b0);
        run(8);
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            step($urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0 ? 10'(1015 + $urandom_range(0, 8)) : 10'($urandom),
                 $urandom_range(0, 4) == 0);
        end
        repeat (2) @(negedge Clock);
        check("drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have port Clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset; 0 resets all state immediately.
REQ-003 The block SHALL have port iInstr, input, 16 bits: instruction memory read data; [15:10] is the opcode, [9:0] is the data field; valid one cycle after the address is presented.
REQ-004 The block SHALL have port iBranchTaken, input, 1 bit: redirect request from the decode stage.
REQ-005 The block SHALL have port iBranchTarget, input, 10 bits: redirect address, sampled only while iBranchTaken=1.
REQ-006 The block SHALL have port iStall, input, 1 bit: hold request from downstream.
REQ-007 The block SHALL have port oInstrAddr, output, 10 bits: combinational next-fetch address to the synchronous instruction memory.
REQ-008 The block SHALL have port oOperation_IF, output, 6 bits: registered opcode to decode.
REQ-009 The block SHALL have port oData_IF, output, 10 bits: registered data field to decode.
REQ-010 The block SHALL have port oPC, output, 10 bits: address of the instruction currently on oOperation_IF/oData_IF.

Function
REQ-011 The FSM SHALL have states BOOT, RUN and (if enabled) HALTED.
REQ-012 In BOOT: oInstrAddr=0, the output register loads NOP/0, and the FSM SHALL go to RUN after one cycle.
REQ-013 In RUN with no stall and no branch, the output register SHALL load iInstr, oPC SHALL load PC, PC SHALL increment, and oInstrAddr SHALL be PC+1.
REQ-014 Throughput in steady state SHALL be one instruction per cycle, with 1-cycle memory latency plus 1 output register.
REQ-015 PC arithmetic SHALL be 10-bit modulo: 1023+1 wraps to 0 with no flag and no stall.
REQ-016 When iBranchTaken=1, oInstrAddr SHALL be iBranchTarget, PC SHALL load iBranchTarget, and the output register SHALL load NOP/0, flushing the wrong-path instruction.
REQ-017 The instruction at the branch target SHALL appear on the outputs two edges after the branch cycle.
REQ-018 When iStall=1 and iBranchTaken=0, the output register, oPC and PC SHALL hold, and oInstrAddr SHALL be PC so that memory data stays stable.
REQ-019 iBranchTaken SHALL take priority over iStall: a branch during a stall redirects and flushes.
REQ-020 A branch in BOOT SHALL be honoured exactly as in RUN, with the FSM going to RUN.
REQ-021 Consecutive branch cycles SHALL each redirect; the last target wins.

Reset
REQ-022 On Reset=0 the block SHALL asynchronously set PC=0, oOperation_IF=NOP, oData_IF=0, oPC=0 and FSM=BOOT.
REQ-023 On Reset=0, oInstrAddr SHALL be 0 while Reset is low.
REQ-024 On reset deassertion the block SHALL spend exactly one cycle in BOOT before the first fetch from address 0 reaches the outputs.
REQ-025 A reset asserted mid-branch or mid-stall SHALL discard all pending redirect and stall state.

Configuration
REQ-026 The block SHALL support macro IF_HALT_EN.
REQ-027 With IF_HALT_EN defined, loading the HALT opcode into the output register without a simultaneous branch SHALL enter HALTED.
REQ-028 In HALTED: HALT stays on the outputs for one cycle, then NOP/0 is output, PC holds, and oInstrAddr=PC.
REQ-029 In HALTED, iBranchTaken=1 SHALL redirect and return the FSM to RUN, covering a branch issued in HALT's shadow.
REQ-030 Exit from HALTED otherwise SHALL be by Reset only.
REQ-031 Without IF_HALT_EN, HALTED SHALL not exist and HALT SHALL pass through as an ordinary opcode.

Structure
REQ-032 The opcode constants (NOP, BAEQ, HALT) and the instruction field widths/offsets SHALL live in the shared definitions include file used by all pipeline stages.
REQ-033 The FSM state encodings SHALL be local to the block.
REQ-034 One sub-module, pc_register, SHALL hold PC with the next-PC mux: branch > stall > increment.
REQ-035 instruction_fetch SHALL instantiate pc_register and own the FSM and output register.

Verification
REQ-036 Reset release, memory mem[i]={6'h01,10'(i)}, no stall -> outputs NOP for 1 cycle, then op 01 with data 0,1,2,... and oPC 0,1,2,... one per cycle.
REQ-037 Straight-line from 1020 (forced by branch) -> oPC sequence 1020..1023,0,1 with no bubble at the wrap.
REQ-038 iBranchTaken=1 with iBranchTarget=200 while oPC=5 -> next cycle NOP/0, following cycle oPC=200 with mem[200] contents, then 201.
REQ-039 iStall=1 for 3 cycles at oPC=7 -> outputs and oPC hold at 7 for 3 cycles, then 8 on the first cycle after release, with no instruction skipped or repeated.
REQ-040 iStall=1 and iBranchTaken=1 with target 50 in the same cycle -> branch wins: NOP, then oPC=50.
REQ-041 With IF_HALT_EN, HALT at address 10 -> HALT shown once, then NOP forever with oInstrAddr=11.
REQ-042 With IF_HALT_EN, a branch to 30 after HALT -> resumes at oPC=30.
REQ-043 With IF_HALT_EN, Reset pulsed mid-stream -> outputs NOP/0 immediately, then restart at 0.
